// File: rtl/mem_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_sequencer
// Purpose  : Owns the single synchronous SRAM port and the core's reset.
//            Shares the port between the core and a host/loader requester,
//            holds the core in reset while the host loads memory, then boots
//            the core by presenting the reset-vector word on the read bus.
//            The core cannot stall, so in RUN it always wins the port and the
//            host only gets the cycles in which the core is idle.
// Ports    : clk, rst_n             clock, async active-low reset
//            core_rst               active-high reset to the core
//            core_mem_*/core_wdata  core request side; core_rdata = sram_rdata
//            core_host_trap         core trap indication
//            host_req/we/addr/size/wdata, host_gnt, host_rvalid, host_rdata
//                                   host request/grant/read-return side
//            host_run, host_halt    start / stop pulses
//            halted, trap_seen      status
//            sram_*                 SRAM port (read data valid 1 cycle later)
// Config   : TRAP_HALT_EN - when defined, a core trap in RUN also halts.
// Sizes    : access size encoding 0=byte, 1=half, 2=word.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_sequencer #(
    parameter int               WDATA          = 32,
    parameter int               WPTR           = 32,
    parameter logic [WPTR-1:0]  RESET_VEC_ADDR = 32'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             core_rst,
    input  logic             core_mem_read,
    input  logic             core_mem_wren,
    input  logic [WPTR-1:0]  core_mem_addr,
    input  logic [1:0]       core_mem_size,
    input  logic [WDATA-1:0] core_wdata,
    output logic [WDATA-1:0] core_rdata,
    input  logic             core_host_trap,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [WPTR-1:0]  host_addr,
    input  logic [1:0]       host_size,
    input  logic [WDATA-1:0] host_wdata,
    output logic             host_gnt,
    output logic             host_rvalid,
    output logic [WDATA-1:0] host_rdata,
    input  logic             host_run,
    input  logic             host_halt,
    output logic             halted,
    output logic             trap_seen,
    output logic             sram_read,
    output logic             sram_wren,
    output logic [WPTR-1:0]  sram_addr,
    output logic [1:0]       sram_size,
    output logic [WDATA-1:0] sram_wdata,
    input  logic [WDATA-1:0] sram_rdata
);

    localparam logic [1:0] MEM_W = 2'd2;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_BOOT = 2'd1,
        S_VEC  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   rvalid_q, rvalid_d;
    logic   trap_q,   trap_d;
    logic   core_active;

    assign core_active = core_mem_read | core_mem_wren;

    // Read data is not registered here: the SRAM already delivers it one
    // cycle after the strobe, which is when both consumers expect it.
    assign core_rdata  = sram_rdata;
    assign host_rdata  = sram_rdata;
    assign core_rst    = (state_q != S_RUN);
    assign halted      = (state_q == S_HALT);
    assign host_rvalid = rvalid_q;
    assign trap_seen   = trap_q;

    // ------------------------------------------------------------------
    // Next-state logic (halt has priority over run everywhere)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALT: if (!host_halt && host_run) state_d = S_BOOT;
            S_BOOT: state_d = host_halt ? S_HALT : S_VEC;
            S_VEC:  state_d = host_halt ? S_HALT : S_RUN;
            S_RUN: begin
`ifdef TRAP_HALT_EN
                if (host_halt || core_host_trap) state_d = S_HALT;
`else
                if (host_halt) state_d = S_HALT;
`endif
            end
            default: state_d = S_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // Port arbitration. The host path is the default routing; BOOT and an
    // active core in RUN override it. Strobes are only raised for a granted
    // requester so the SRAM never sees idle accesses.
    // ------------------------------------------------------------------
    always_comb begin
        host_gnt   = 1'b0;
        sram_read  = 1'b0;
        sram_wren  = 1'b0;
        sram_addr  = host_addr;
        sram_size  = host_size;
        sram_wdata = host_wdata;
        case (state_q)
            S_BOOT: begin
                sram_read = 1'b1;
                sram_addr = RESET_VEC_ADDR;
                sram_size = MEM_W;
            end
            S_RUN: begin
                if (core_active) begin
                    // Write wins if the core ever raises both, keeping the
                    // strobes mutually exclusive.
                    sram_wren  = core_mem_wren;
                    sram_read  = core_mem_read & ~core_mem_wren;
                    sram_addr  = core_mem_addr;
                    sram_size  = core_mem_size;
                    sram_wdata = core_wdata;
                end else begin
                    host_gnt = host_req;
                end
            end
            default: host_gnt = host_req;
        endcase
        if (host_gnt) begin
            sram_read = ~host_we;
            sram_wren = host_we;
        end
    end

    // A trap in the same cycle as a run pulse is kept: it was observed at
    // or after that run.
    always_comb begin
        rvalid_d = host_gnt & ~host_we;
        trap_d   = trap_q;
        if (host_run) trap_d = 1'b0;
        if (state_q == S_RUN && core_host_trap) trap_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HALT;
            rvalid_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            trap_q   <= trap_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_sequencer
// Purpose  : Directed self-checking bench for mem_port_sequencer with a small
//            synchronous SRAM model (word-indexed, one-cycle read latency).
//            Inputs change on the falling edge; outputs are sampled 1 time
//            unit later, well away from the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_rst;
    logic        core_mem_read, core_mem_wren;
    logic [31:0] core_mem_addr;
    logic [1:0]  core_mem_size;
    logic [31:0] core_wdata, core_rdata;
    logic        core_host_trap;
    logic        host_req, host_we;
    logic [31:0] host_addr;
    logic [1:0]  host_size;
    logic [31:0] host_wdata;
    logic        host_gnt, host_rvalid;
    logic [31:0] host_rdata;
    logic        host_run, host_halt;
    logic        halted, trap_seen;
    logic        sram_read, sram_wren;
    logic [31:0] sram_addr;
    logic [1:0]  sram_size;
    logic [31:0] sram_wdata, sram_rdata;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_sequencer #(
        .WDATA          (32),
        .WPTR           (32),
        .RESET_VEC_ADDR (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_rst       (core_rst),
        .core_mem_read  (core_mem_read),
        .core_mem_wren  (core_mem_wren),
        .core_mem_addr  (core_mem_addr),
        .core_mem_size  (core_mem_size),
        .core_wdata     (core_wdata),
        .core_rdata     (core_rdata),
        .core_host_trap (core_host_trap),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_size      (host_size),
        .host_wdata     (host_wdata),
        .host_gnt       (host_gnt),
        .host_rvalid    (host_rvalid),
        .host_rdata     (host_rdata),
        .host_run       (host_run),
        .host_halt      (host_halt),
        .halted         (halted),
        .trap_seen      (trap_seen),
        .sram_read      (sram_read),
        .sram_wren      (sram_wren),
        .sram_addr      (sram_addr),
        .sram_size      (sram_size),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata)
    );

    // SRAM model; preloaded with A5A5_00ii while the bench holds reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 + i;
            sram_rdata <= 32'h0;
        end else begin
            if (sram_wren) mem[sram_addr[9:2]] <= sram_wdata;
            if (sram_read) sram_rdata <= mem[sram_addr[9:2]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        core_mem_read = 0; core_mem_wren = 0; core_mem_addr = 0;
        core_mem_size = 2'd2; core_wdata = 0; core_host_trap = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_size = 2'd2;
        host_wdata = 0; host_run = 0; host_halt = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        nedge(); #1;
        check_eq("rst_core_rst", core_rst, 1);
        check_eq("rst_halted", halted, 1);
        check_eq("rst_trap_seen", trap_seen, 0);
        check_eq("rst_rvalid", host_rvalid, 0);

        // HALT: host writes 0x100 to addr 0; core request must be ignored
        nedge(); rst_n = 1'b1;
        host_req = 1; host_we = 1; host_addr = 32'h0; host_wdata = 32'h100;
        core_mem_read = 1; core_mem_addr = 32'h40;
        #1;
        check_eq("halt_gnt", host_gnt, 1);
        check_eq("halt_wren", sram_wren, 1);
        check_eq("halt_read", sram_read, 0);
        check_eq("halt_addr", sram_addr, 32'h0);
        check_eq("halt_core_rst", core_rst, 1);
        check_eq("halt_halted", halted, 1);

        // run pulse
        nedge(); clear_inputs(); host_run = 1; #1;
        check_eq("run_pulse_halted", halted, 1);

        // BOOT: vector read, host blocked
        nedge(); clear_inputs(); host_req = 1; host_addr = 32'h4; #1;
        check_eq("boot_gnt", host_gnt, 0);
        check_eq("boot_read", sram_read, 1);
        check_eq("boot_addr", sram_addr, 32'h0);
        check_eq("boot_size", sram_size, 2);
        check_eq("boot_core_rst", core_rst, 1);
        check_eq("boot_halted", halted, 0);

        // VEC: vector word visible, host may be granted
        nedge(); #1;
        check_eq("vec_rdata", core_rdata, 32'h100);
        check_eq("vec_core_rst", core_rst, 1);
        check_eq("vec_gnt", host_gnt, 1);
        check_eq("vec_addr", sram_addr, 32'h4);

        // RUN: host read from VEC returns; then core and host contend
        nedge();
        clear_inputs();
        core_mem_read = 1; core_mem_addr = 32'h8;
        host_req = 1; host_addr = 32'hC;
        #1;
        check_eq("run_core_rst", core_rst, 0);
        check_eq("vec_rvalid", host_rvalid, 1);
        check_eq("vec_host_rdata", host_rdata, 32'hA5A5_0001);
        check_eq("contend_gnt", host_gnt, 0);
        check_eq("contend_addr", sram_addr, 32'h8);
        check_eq("contend_read", sram_read, 1);

        nedge(); core_mem_read = 0; #1;
        check_eq("contend_rvalid", host_rvalid, 0);
        check_eq("core_rdata", core_rdata, 32'hA5A5_0002);
        check_eq("idle_gnt", host_gnt, 1);
        check_eq("idle_addr", sram_addr, 32'hC);

        nedge(); host_req = 0; #1;
        check_eq("idle_rvalid", host_rvalid, 1);
        check_eq("idle_host_rdata", host_rdata, 32'hA5A5_0003);
        check_eq("no_strobe_rd", sram_read, 0);
        check_eq("no_strobe_wr", sram_wren, 0);

        // core write in the halt cycle still completes
        nedge();
        core_mem_wren = 1; core_mem_addr = 32'h10; core_wdata = 32'hDEAD_BEEF;
        host_halt = 1;
        #1;
        check_eq("hw_wren", sram_wren, 1);
        check_eq("hw_read", sram_read, 0);
        check_eq("hw_wdata", sram_wdata, 32'hDEAD_BEEF);
        check_eq("hw_core_rst", core_rst, 0);

        nedge(); clear_inputs(); #1;
        check_eq("hw_after_core_rst", core_rst, 1);
        check_eq("hw_after_halted", halted, 1);
        check_eq("hw_mem4", mem[4], 32'hDEAD_BEEF);

        // run+halt together in HALT -> stay HALT
        host_run = 1; host_halt = 1;
        nedge(); clear_inputs(); #1;
        check_eq("runhalt_halted", halted, 1);

        // boot, then halt in VEC
        host_run = 1;
        nedge(); clear_inputs(); #1;
        check_eq("boot2_halted", halted, 0);
        nedge(); host_halt = 1; #1;
        check_eq("vec_halt_core_rst", core_rst, 1);
        nedge(); clear_inputs(); #1;
        check_eq("vec_halt_halted", halted, 1);
        check_eq("vec_halt_core_rst2", core_rst, 1);

        // full boot into RUN, then trap
        host_run = 1;
        nedge(); clear_inputs();
        nedge();
        nedge(); #1;
        check_eq("run2_core_rst", core_rst, 0);
        check_eq("run2_trap_seen", trap_seen, 0);
        core_host_trap = 1;
        nedge(); clear_inputs(); #1;
        check_eq("trap_seen", trap_seen, 1);
`ifdef TRAP_HALT_EN
        check_eq("trap_halted", halted, 1);
`else
        check_eq("trap_halted", halted, 0);
        check_eq("trap_core_rst", core_rst, 0);
        host_halt = 1;
        nedge(); clear_inputs(); #1;
        check_eq("trap_halt_halted", halted, 1);
`endif
        host_run = 1; #1;
        check_eq("trap_sticky", trap_seen, 1);
        nedge(); clear_inputs(); #1;
        check_eq("trap_cleared", trap_seen, 0);
        nedge();
        nedge(); #1;
        check_eq("run3_core_rst", core_rst, 0);

        // async reset with a host read pending
        host_req = 1; host_addr = 32'h14; #1;
        check_eq("pend_gnt", host_gnt, 1);
        rst_n = 1'b0; #1;
        check_eq("arst_core_rst", core_rst, 1);
        check_eq("arst_halted", halted, 1);
        check_eq("arst_rvalid", host_rvalid, 0);
        nedge(); #1;
        check_eq("arst_rvalid2", host_rvalid, 0);
        clear_inputs();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
